// File: rtl/lfsr_rng_arbiter.sv
// Round-robin shared 8-bit Galois LFSR: each grant steps the LFSR STEPS times, then delivers value + div flags.
// Optional delivery counter enabled by defining LFSR_RNG_STATS_EN.
module lfsr_rng_arbiter #(
   parameter int         NUM_REQ = 4,
   parameter logic [7:0] SEED    = 8'h97,
   parameter int         STEPS   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               seed_load,
   input  logic [7:0]         seed_val,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               rnd_valid,
   output logic [7:0]         rnd_data,
   output logic [2:0]         rnd_flags,
   output logic               busy
`ifdef LFSR_RNG_STATS_EN
   ,
   output logic [15:0]        deliv_count
`endif
);

   localparam int          PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned NR       = NUM_REQ;
   localparam logic [3:0]  CNT_LAST = 4'(STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STEP,
      S_DELIVER
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] win_q, win_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    data_q, data_d;
   logic [2:0]    flags_q, flags_d;
   logic [7:0]    lfsr_shift;

   logic          pick_found;
   logic [PW-1:0] pick_idx;

`ifdef LFSR_RNG_STATS_EN
   logic [15:0]   count_q, count_d;
`endif

   // Galois form of x^8+x^6+x^5+x^4+1: feedback from bit 7 into bits 0,4,5,6.
   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      logic [7:0] n;
      n[0] = l[7];
      n[1] = l[0];
      n[2] = l[1];
      n[3] = l[2];
      n[4] = l[3] ^ l[7];
      n[5] = l[4] ^ l[7];
      n[6] = l[5] ^ l[7];
      n[7] = l[6];
      return n;
   endfunction

   function automatic logic [2:0] div_flags(input logic [7:0] v);
      logic [2:0] f;
      f[2] = (v[0] == 1'b0);
      f[1] = ((v % 8'd3) == 8'd0);
      f[0] = ((v % 8'd5) == 8'd0);
      return f;
   endfunction

   assign lfsr_shift = lfsr_next(lfsr_q);

   // Cyclic scan starting at the round-robin pointer.
   always_comb begin
      int unsigned pos;
      pick_found = 1'b0;
      pick_idx   = '0;
      pos        = 0;
      for (int unsigned i = 0; i < NR; i++) begin
         pos = (32'(ptr_q) + i) % NR;
         if (!pick_found && req[pos]) begin
            pick_found = 1'b1;
            pick_idx   = PW'(pos);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      flags_d = flags_q;
`ifdef LFSR_RNG_STATS_EN
      count_d = count_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (seed_load) begin
               lfsr_d = (seed_val == 8'h00) ? SEED : seed_val;
`ifdef LFSR_RNG_STATS_EN
               count_d = '0;
`endif
            end else if (pick_found) begin
               win_d   = pick_idx;
               cnt_d   = '0;
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            lfsr_d = lfsr_shift;
            cnt_d  = cnt_q + 4'd1;
            // Capture the final shifted value here so the outputs come straight from flops in DELIVER.
            if (cnt_q == CNT_LAST) begin
               data_d  = lfsr_shift;
               flags_d = div_flags(lfsr_shift);
               state_d = S_DELIVER;
            end
         end
         S_DELIVER: begin
            ptr_d   = (win_q == PW'(NR - 1)) ? '0 : win_q + PW'(1);
            state_d = S_IDLE;
`ifdef LFSR_RNG_STATS_EN
            if (count_q != 16'hFFFF) begin
               count_d = count_q + 16'd1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED;
         ptr_q   <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         flags_q <= '0;
`ifdef LFSR_RNG_STATS_EN
         count_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         flags_q <= flags_d;
`ifdef LFSR_RNG_STATS_EN
         count_q <= count_d;
`endif
      end
   end

   always_comb begin
      gnt = '0;
      if (state_q == S_DELIVER) begin
         gnt[win_q] = 1'b1;
      end
   end

   assign rnd_valid = (state_q == S_DELIVER);
   assign busy      = (state_q != S_IDLE);
   assign rnd_data  = data_q;
   assign rnd_flags = flags_q;

`ifdef LFSR_RNG_STATS_EN
   assign deliv_count = count_q;
`endif

endmodule
